uart_tx_ctrl: RTL

Frame-level transmitter FSM for the UART TX path. It accepts a parallel byte over a valid/ready handshake and serialises it onto tx_o as start bit, data bits (LSB first), optional parity, then stop bits. Bit timing comes from the upstream baud counter: this block consumes its overflow flag (baud_tick_i) and restarts it through clear_baud_o. It sits between the host-side producer and the TX pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART TX path
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  // Widest legal data word; narrower words are zero-extended, which leaves XOR parity unchanged.
  localparam int unsigned MAX_DATA_BITS = 9;

  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - frame-level UART transmitter FSM (start, data LSB first, parity, stop)
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic                 baud_tick_i,
  output logic                 clear_baud_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic ODD_SEL = (PARITY_ODD != 0);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_ctrl: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 clear_q, clear_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic [MAX_DATA_BITS-1:0] data_ext;

  // The baud flag is stale in the cycle the counter is being cleared.
  assign tick     = baud_tick_i && !clear_q;
  assign data_ext = MAX_DATA_BITS'(tx_data_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= IDLE_LEVEL;
      clear_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      clear_q    <= clear_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    clear_d    = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (tx_valid_i) begin
          shift_d    = tx_data_i;
          parity_d   = calc_parity(data_ext, ODD_SEL);
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          clear_d    = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          clear_d   = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          clear_d = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          clear_d    = 1'b1;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
            clear_d    = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase
  end

  assign tx_ready_o   = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign tx_o         = tx_q;
  assign clear_baud_o = clear_q;
  assign done_o       = done_q;

endmodule
